// File: rtl/fetch_pkg.sv
// Shared constants and state encoding for the instruction fetch controller.
package fetch_pkg;
  localparam int FETCH_ADDR_W = 16;
  localparam int FETCH_DATA_W = 16;

  localparam logic [3:0] OPC_JMP  = 4'hE;
  localparam logic [3:0] OPC_HALT = 4'hF;

  typedef enum logic [1:0] {IDLE, FETCH, HALTED} fetch_state_t;
endpackage

// File: rtl/fetch_controller.sv
// Fetch sequencer: steers prog_counter's load port, resolves JMP/HALT/branch
// redirects and presents fetched words to execute over valid/ready.
module fetch_controller
  import fetch_pkg::*;
#(
  parameter int ADDR_W = FETCH_ADDR_W,
  parameter int DATA_W = FETCH_DATA_W
) (
  input  logic              sys_clk,
  input  logic              reset_raw,
  input  logic              run,
  input  logic [ADDR_W-1:0] pc_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic              pc_load_enable,
  output logic [ADDR_W-1:0] pc_load_data,
  input  logic              branch_req,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_addr,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic              halted
);

  fetch_state_t state, state_nxt;

  logic [3:0]        opc;
  logic              is_jmp, is_halt, slot_free;
  logic [ADDR_W-1:0] jmp_target;

  assign opc        = mem_data[DATA_W-1 -: 4];
  assign is_jmp     = (opc == OPC_JMP);
  assign is_halt    = (opc == OPC_HALT);
  assign jmp_target = ADDR_W'(mem_data[11:0]);
  assign slot_free  = !instr_valid || instr_ready;

  always_ff @(posedge sys_clk) begin
    if (!reset_raw) state <= IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:   if (run) state_nxt = FETCH;
      FETCH: begin
        if (branch_req || !slot_free) state_nxt = FETCH;
        else if (!run)                state_nxt = IDLE;
        else if (is_halt)             state_nxt = HALTED;
      end
      HALTED: state_nxt = HALTED;
      default: state_nxt = IDLE;
    endcase
  end

  // Counter port defaults to hold; only a plain fetch lets it increment.
  always_comb begin
    pc_load_enable = 1'b1;
    pc_load_data   = pc_addr;
    if (state == FETCH) begin
      if (branch_req)                     pc_load_data   = branch_target;
      else if (!slot_free || !run)        pc_load_data   = pc_addr;
      else if (is_jmp)                    pc_load_data   = jmp_target;
      else if (!is_halt)                  pc_load_enable = 1'b0;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!reset_raw) begin
      instr       <= '0;
      instr_addr  <= '0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
    end else begin
      halted <= (state_nxt == HALTED);
      if (state == FETCH) begin
        if (branch_req) begin
          instr_valid <= 1'b0;
        end else if (slot_free) begin
          if (!run || is_jmp || is_halt) begin
            instr_valid <= 1'b0;
          end else begin
            instr       <= mem_data;
            instr_addr  <= pc_addr;
            instr_valid <= 1'b1;
          end
        end
      end else if (instr_ready) begin
        instr_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_controller.sv
// Self-checking bench: behavioural counter/memory around the controller,
// scoreboard of expected transfers plus direct cycle checks.
module tb_fetch_controller;

  localparam int AW = 16;
  localparam int DW = 16;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;

  logic          sys_clk = 1'b0;
  logic          reset_raw;
  logic          run;
  logic [AW-1:0] pc_addr;
  logic [DW-1:0] mem_data;
  logic          pc_load_enable;
  logic [AW-1:0] pc_load_data;
  logic          branch_req;
  logic [AW-1:0] branch_target;
  logic [DW-1:0] instr;
  logic [AW-1:0] instr_addr;
  logic          instr_valid;
  logic          instr_ready;
  logic          halted;

  logic [DW-1:0] mem [0:65535];
  exp_t          exp_q[$];
  int            n_chk = 0;
  int            n_fail = 0;

  always #5 sys_clk = ~sys_clk;

  // prog_counter model
  always @(posedge sys_clk) begin
    if (!reset_raw)          pc_addr <= '0;
    else if (pc_load_enable) pc_addr <= pc_load_data;
    else                     pc_addr <= pc_addr + 1'b1;
  end

  always_comb mem_data = mem[pc_addr];

  fetch_controller #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .sys_clk        (sys_clk),
    .reset_raw      (reset_raw),
    .run            (run),
    .pc_addr        (pc_addr),
    .mem_data       (mem_data),
    .pc_load_enable (pc_load_enable),
    .pc_load_data   (pc_load_data),
    .branch_req     (branch_req),
    .branch_target  (branch_target),
    .instr          (instr),
    .instr_addr     (instr_addr),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .halted         (halted)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic push_exp(input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 65536; i++) mem[i] = '0;
  endtask

  task automatic do_reset();
    run = 1'b0; instr_ready = 1'b0; branch_req = 1'b0; branch_target = '0;
    reset_raw = 1'b0;
    step();
    reset_raw = 1'b1;
  endtask

  // Transfers happen on edges where valid && ready; sample on the falling edge before.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge sys_clk);
      if (reset_raw && instr_valid && instr_ready) begin
        if (exp_q.size() == 0) begin
          chk("sb_underflow", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          chk("sb_data", 32'(instr), 32'(e.data));
          chk("sb_addr", 32'(instr_addr), 32'(e.addr));
        end
      end
    end
  end

  initial begin : stim
    reset_raw = 1'b0; run = 1'b0; instr_ready = 1'b0;
    branch_req = 1'b0; branch_target = '0;
    clear_mem();
    step(2);
    chk("rst_instr", 32'(instr), 32'h0);
    chk("rst_addr", 32'(instr_addr), 32'h0);
    chk("rst_valid", 32'(instr_valid), 32'h0);
    chk("rst_halted", 32'(halted), 32'h0);
    chk("rst_ld_en", 32'(pc_load_enable), 32'h1);
    chk("rst_pc", 32'(pc_addr), 32'h0);
    reset_raw = 1'b1;
    step();
    chk("idle_hold", 32'(pc_addr), 32'h0);

    // straight-line
    clear_mem();
    for (int i = 0; i < 5; i++) mem[i] = 16'h1001 + 16'(i);
    for (int i = 0; i < 4; i++) push_exp(AW'(i), 16'h1001 + 16'(i));
    do_reset();
    run = 1'b1; instr_ready = 1'b1;
    step(2);
    chk("sl_ld_en", 32'(pc_load_enable), 32'h0);
    for (int i = 0; i < 4; i++) begin
      chk("sl_instr", 32'(instr), 32'h1001 + 32'(i));
      chk("sl_addr", 32'(instr_addr), 32'(i));
      chk("sl_valid", 32'(instr_valid), 32'h1);
      if (i == 3) run = 1'b0;
      step();
    end
    chk("sl_stop_valid", 32'(instr_valid), 32'h0);
    chk("sl_drain", 32'(exp_q.size()), 32'h0);

    // stall
    clear_mem();
    for (int i = 0; i < 5; i++) mem[i] = 16'h1001 + 16'(i);
    for (int i = 0; i < 4; i++) push_exp(AW'(i), 16'h1001 + 16'(i));
    do_reset();
    run = 1'b1; instr_ready = 1'b1;
    step(3);
    instr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("st_instr", 32'(instr), 32'h1002);
      chk("st_addr", 32'(instr_addr), 32'h1);
      chk("st_pc", 32'(pc_addr), 32'h2);
    end
    instr_ready = 1'b1;
    step();
    chk("st_resume", 32'(instr), 32'h1003);
    step();
    chk("st_next", 32'(instr), 32'h1004);
    run = 1'b0;
    step();
    chk("st_drain", 32'(exp_q.size()), 32'h0);

    // JMP
    clear_mem();
    mem[0] = 16'h1001; mem[1] = 16'h1002; mem[2] = 16'hE010;
    mem[16'h10] = 16'h2222; mem[16'h11] = 16'h3333;
    push_exp(16'h0, 16'h1001); push_exp(16'h1, 16'h1002); push_exp(16'h10, 16'h2222);
    do_reset();
    run = 1'b1; instr_ready = 1'b1;
    step(4);
    chk("jmp_bubble", 32'(instr_valid), 32'h0);
    chk("jmp_pc", 32'(pc_addr), 32'h10);
    step();
    chk("jmp_instr", 32'(instr), 32'h2222);
    chk("jmp_addr", 32'(instr_addr), 32'h10);
    run = 1'b0;
    step();
    chk("jmp_drain", 32'(exp_q.size()), 32'h0);

    // branch during stall drops the stalled word
    clear_mem();
    mem[0] = 16'h1001; mem[1] = 16'h1002;
    mem[16'h40] = 16'h4444; mem[16'h41] = 16'h4445;
    push_exp(16'h40, 16'h4444);
    do_reset();
    run = 1'b1; instr_ready = 1'b1;
    step(2);
    instr_ready = 1'b0;
    step();
    chk("br_stall_pc", 32'(pc_addr), 32'h1);
    branch_req = 1'b1; branch_target = 16'h0040;
    step();
    branch_req = 1'b0; instr_ready = 1'b1;
    chk("br_flush", 32'(instr_valid), 32'h0);
    chk("br_pc", 32'(pc_addr), 32'h40);
    step();
    chk("br_instr", 32'(instr), 32'h4444);
    chk("br_addr", 32'(instr_addr), 32'h40);
    run = 1'b0;
    step();
    chk("br_drain", 32'(exp_q.size()), 32'h0);

    // HALT then reset
    clear_mem();
    mem[0] = 16'h1001; mem[1] = 16'h1002; mem[2] = 16'h1003; mem[3] = 16'hF000;
    for (int i = 0; i < 3; i++) push_exp(AW'(i), 16'h1001 + 16'(i));
    do_reset();
    run = 1'b1; instr_ready = 1'b1;
    step(5);
    chk("h_halted", 32'(halted), 32'h1);
    chk("h_valid", 32'(instr_valid), 32'h0);
    chk("h_pc", 32'(pc_addr), 32'h3);
    branch_req = 1'b1; branch_target = 16'h0040;
    step();
    branch_req = 1'b0;
    step(2);
    chk("h_br_ign_pc", 32'(pc_addr), 32'h3);
    chk("h_still", 32'(halted), 32'h1);
    chk("h_ld_en", 32'(pc_load_enable), 32'h1);
    run = 1'b0; reset_raw = 1'b0;
    step();
    reset_raw = 1'b1;
    chk("hr_halted", 32'(halted), 32'h0);
    chk("hr_valid", 32'(instr_valid), 32'h0);
    chk("hr_pc", 32'(pc_addr), 32'h0);
    chk("hr_drain", 32'(exp_q.size()), 32'h0);

    // wrap 0xFFFF -> 0x0000 with no bubble
    clear_mem();
    mem[16'hFFFF] = 16'h1111; mem[0] = 16'h5000;
    push_exp(16'hFFFF, 16'h1111); push_exp(16'h0000, 16'h5000);
    do_reset();
    run = 1'b1; instr_ready = 1'b1;
    step();
    branch_req = 1'b1; branch_target = 16'hFFFF;
    step();
    branch_req = 1'b0;
    step();
    chk("w_addr0", 32'(instr_addr), 32'hFFFF);
    chk("w_valid0", 32'(instr_valid), 32'h1);
    step();
    chk("w_addr1", 32'(instr_addr), 32'h0000);
    chk("w_valid1", 32'(instr_valid), 32'h1);
    run = 1'b0;
    step();
    chk("w_drain", 32'(exp_q.size()), 32'h0);

    step(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
